// File: rtl/axis_conv_pkg.sv
// Shared configuration, page metadata and FSM state types for the paged N->M width converter.
// Page geometry (N, M, LCM) is a codebase-wide setting; the page count is set per instance.
package axis_conv_pkg;

  localparam int CFG_N     = 8;
  localparam int CFG_M     = 3;
  localparam int CFG_LCM   = 24;
  localparam int CFG_PAGES = 4;

  localparam int KN     = CFG_LCM / CFG_N;  // input slots per page
  localparam int KM     = CFG_LCM / CFG_M;  // output words per full page
  localparam int FILL_W = $clog2(CFG_LCM + 1);

  typedef struct packed {
    logic              first;
    logic              last;
    logic [FILL_W-1:0] fill;
  } page_meta_t;

  typedef enum logic {W_IDLE, W_FILL} wr_state_t;
  typedef enum logic {R_IDLE, R_EMIT} rd_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/axis_conv_page_mem.sv
// Page store: PAGES x LCM bits, one N-bit slot write port and one M-bit word read port
// that zeroes every bit at or beyond the page fill level.
module axis_conv_page_mem
  import axis_conv_pkg::*;
#(
  parameter int N     = CFG_N,
  parameter int M     = CFG_M,
  parameter int LCM   = CFG_LCM,
  parameter int PAGES = CFG_PAGES,
  localparam int PW    = $clog2(PAGES),
  localparam int SLOTS = LCM / N,
  localparam int WORDS = LCM / M,
  localparam int SW    = $clog2(SLOTS),
  localparam int JW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PW-1:0]     wr_page,
  input  logic [SW-1:0]     wr_slot,
  input  logic [N-1:0]      wr_data,
  input  logic [PW-1:0]     rd_page,
  input  logic [JW-1:0]     rd_word,
  input  logic [FILL_W-1:0] rd_fill,
  output logic [M-1:0]      rd_data
);

  logic [LCM-1:0] mem [PAGES];

  // NOTE: the array has no reset; stale bits are never visible because reads are masked by fill.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (wr_slot == SW'(s)) mem[wr_page][LCM-1-s*N -: N] <= wr_data;
      end
    end
  end

  // Bit i of word w sits at MSB-relative position w*M + (M-1-i).
  always_comb begin
    rd_data = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (rd_word == JW'(w)) begin
        for (int i = 0; i < M; i++) begin
          if (int'(rd_fill) > w*M + M-1-i) rd_data[i] = mem[rd_page][LCM-M-w*M+i];
        end
      end
    end
  end

endmodule

// File: rtl/axis_width_conv_paged.sv
// Framed N->M width converter staging data in a ring of LCM-bit pages.
// Write FSM packs input words into pages; read side unpacks committed pages into M-bit words.
module axis_width_conv_paged
  import axis_conv_pkg::*;
#(
  parameter int N     = CFG_N,
  parameter int M     = CFG_M,
  parameter int LCM   = CFG_LCM,
  parameter int PAGES = CFG_PAGES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  s_axis_tdata,
  input  logic          s_axis_tfirst,
  input  logic          s_axis_tlast,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tnext,
  input  logic          m_axis_tnext,
  output logic [M-1:0]  m_axis_tdata,
  output logic          m_axis_tfirst,
  output logic          m_axis_tlast,
  output logic          m_axis_tvalid,
  output logic          frame_err,
  output logic [15:0]   bit_count
);

  localparam int PW = $clog2(PAGES);
  localparam int UW = $clog2(PAGES + 1);
  localparam int SW = $clog2(KN);
  localparam int JW = $clog2(KM);

  if (N != CFG_N || M != CFG_M || LCM != CFG_LCM) begin : g_geom_chk
    $error("axis_width_conv_paged: N/M/LCM must match axis_conv_pkg");
  end
  if (PAGES * LCM > 65535) begin : g_cap_chk
    $error("axis_width_conv_paged: PAGES*LCM exceeds the 16-bit bit_count range");
  end
  if (PAGES < 2 || (PAGES & (PAGES - 1)) != 0) begin : g_pages_chk
    $error("axis_width_conv_paged: PAGES must be a power of 2 and >= 2");
  end

  wr_state_t     wr_state, wr_state_nxt;
  rd_state_t     rd_state, rd_state_nxt;
  logic [SW-1:0] slot, slot_nxt;
  logic          open_first, open_first_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_p1;
  logic [UW-1:0] pages_used, pages_used_nxt;
  logic [JW-1:0] rd_word, rd_word_nxt;
  logic [15:0]   bit_count_nxt;
  logic          up;

  page_meta_t    meta [PAGES];
  page_meta_t    cur, meta_a, meta_b;
  logic          meta_a_we, meta_b_we;
  logic [PW-1:0] mem_page;
  logic [SW-1:0] mem_slot;
  logic [M-1:0]  rd_data;

  logic          first_flag, err_case, accept;
  logic          pop, pop_free, last_word;
  int            commits, rem_bits;

  assign wr_ptr_p1 = wr_ptr + PW'(1);
  assign cur       = meta[rd_ptr];

  // Write side: a tfirst inside an open page closes it and restarts in the next page,
  // which can commit two pages in one cycle, so it needs two free pages.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    wr_state_nxt   = wr_state;
    slot_nxt       = slot;
    open_first_nxt = open_first;
    commits        = 0;
    meta_a_we      = 1'b0;
    meta_b_we      = 1'b0;
    meta_a         = '0;
    meta_b         = '0;
    mem_page       = wr_ptr;
    mem_slot       = slot;
    first_flag     = (wr_state == W_IDLE) ? s_axis_tfirst : open_first;
    err_case       = s_axis_tfirst && (wr_state == W_FILL);
    accept         = s_axis_tvalid && up &&
                     (err_case ? (int'(pages_used) <= PAGES - 2) : (int'(pages_used) < PAGES));
    if (accept) begin
      if (err_case) begin
        meta_a_we = 1'b1;
        meta_a    = '{first: open_first, last: 1'b1, fill: FILL_W'(int'(slot) * N)};
        commits   = 1;
        mem_page  = wr_ptr_p1;
        mem_slot  = '0;
        if (s_axis_tlast) begin
          meta_b_we    = 1'b1;
          meta_b       = '{first: 1'b1, last: 1'b1, fill: FILL_W'(N)};
          commits      = 2;
          wr_state_nxt = W_IDLE;
          slot_nxt     = '0;
        end else begin
          wr_state_nxt   = W_FILL;
          slot_nxt       = SW'(1);
          open_first_nxt = 1'b1;
        end
      end else if (s_axis_tlast || int'(slot) == KN - 1) begin
        meta_a_we    = 1'b1;
        meta_a       = '{first: first_flag, last: s_axis_tlast, fill: FILL_W'((int'(slot) + 1) * N)};
        commits      = 1;
        wr_state_nxt = W_IDLE;
        slot_nxt     = '0;
      end else begin
        wr_state_nxt   = W_FILL;
        slot_nxt       = slot + SW'(1);
        open_first_nxt = first_flag;
      end
    end
  end

  // Read side and shared occupancy accounting.
  always_comb begin
    last_word      = (int'(rd_word) == ceil_div(int'(cur.fill), M) - 1);
    rem_bits       = int'(cur.fill) - int'(rd_word) * M;
    pop            = m_axis_tnext && m_axis_tvalid;
    pop_free       = pop && last_word;
    rd_word_nxt    = rd_word;
    if (pop) rd_word_nxt = last_word ? '0 : rd_word + JW'(1);
    pages_used_nxt = UW'(int'(pages_used) + commits - int'(pop_free));
    bit_count_nxt  = 16'(int'(bit_count) + (accept ? N : 0) - (pop ? (last_word ? rem_bits : M) : 0));
    rd_state_nxt   = (pages_used_nxt != '0) ? R_EMIT : R_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state   <= W_IDLE;
      rd_state   <= R_IDLE;
      slot       <= '0;
      open_first <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pages_used <= '0;
      rd_word    <= '0;
      bit_count  <= '0;
      frame_err  <= 1'b0;
      up         <= 1'b0;
    end else begin
      wr_state   <= wr_state_nxt;
      rd_state   <= rd_state_nxt;
      slot       <= slot_nxt;
      open_first <= open_first_nxt;
      wr_ptr     <= wr_ptr + PW'(commits);
      rd_ptr     <= rd_ptr + PW'(pop_free);
      pages_used <= pages_used_nxt;
      rd_word    <= rd_word_nxt;
      bit_count  <= bit_count_nxt;
      frame_err  <= accept && err_case;
      up         <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (meta_a_we) meta[wr_ptr]    <= meta_a;
    if (meta_b_we) meta[wr_ptr_p1] <= meta_b;
  end

  axis_conv_page_mem #(.N(N), .M(M), .LCM(LCM), .PAGES(PAGES)) u_mem (
    .clk     (clk),
    .we      (accept),
    .wr_page (mem_page),
    .wr_slot (mem_slot),
    .wr_data (s_axis_tdata),
    .rd_page (rd_ptr),
    .rd_word (rd_word),
    .rd_fill (cur.fill),
    .rd_data (rd_data)
  );

  assign s_axis_tnext  = accept;
  assign m_axis_tvalid = (rd_state == R_EMIT);
  assign m_axis_tdata  = m_axis_tvalid ? rd_data : '0;
  assign m_axis_tfirst = m_axis_tvalid && cur.first && (rd_word == '0);
  assign m_axis_tlast  = m_axis_tvalid && cur.last && last_word;

endmodule

// File: tb/tb_axis_width_conv_paged.sv
// Directed bench for axis_width_conv_paged (N=8, M=3, LCM=24, PAGES=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_axis_width_conv_paged;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tfirst, s_axis_tlast, s_axis_tvalid, s_axis_tnext;
  logic        m_axis_tnext;
  logic [2:0]  m_axis_tdata;
  logic        m_axis_tfirst, m_axis_tlast, m_axis_tvalid;
  logic        frame_err;
  logic [15:0] bit_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_width_conv_paged #(.N(8), .M(3), .LCM(24), .PAGES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tfirst (s_axis_tfirst),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tnext  (s_axis_tnext),
    .m_axis_tnext  (m_axis_tnext),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tfirst (m_axis_tfirst),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .frame_err     (frame_err),
    .bit_count     (bit_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offer one word and wait (bounded) until it is accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] d, input logic f, input logic l);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tfirst = f;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (s_axis_tnext) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tfirst = 1'b0;
    s_axis_tlast  = 1'b0;
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  // Pop one output word and compare it; returns 1 ns after the popping edge.
  task automatic pop_check(input string tag, input logic [2:0] d, input logic f, input logic l);
    @(negedge clk);
    m_axis_tnext = 1'b1;
    #1;
    check({tag, "_valid"}, 32'(m_axis_tvalid), 32'd1);
    check({tag, "_data"},  32'(m_axis_tdata),  32'(d));
    check({tag, "_first"}, 32'(m_axis_tfirst), 32'(f));
    check({tag, "_last"},  32'(m_axis_tlast),  32'(l));
    @(posedge clk);
    #1;
    m_axis_tnext = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_a [8];
    logic [2:0] exp_b [8];
    logic [2:0] exp_c [8];
    logic [2:0] last_d;
    logic       last_l;
    int         n;

    // 1. Reset: outputs held at zero even with a word offered.
    rst           = 1'b0;
    s_axis_tdata  = 8'hFF;
    s_axis_tfirst = 1'b1;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    m_axis_tnext  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_s_tnext",  32'(s_axis_tnext),  32'd0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
    check("rst_m_tfirst", 32'(m_axis_tfirst), 32'd0);
    check("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
    check("rst_frame_err", 32'(frame_err),    32'd0);
    check("rst_bit_count", 32'(bit_count),    32'd0);
    s_axis_tvalid = 1'b0;
    s_axis_tfirst = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tnext  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);

    // 2. Full page A5,3C,F0 -> 5,1,2,3,6,3,6,0.
    send(8'hA5, 1'b1, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    check("full_tvalid_before_commit", 32'(m_axis_tvalid), 32'd0);
    send(8'hF0, 1'b0, 1'b1);
    check("full_latency_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("full_bit_count", 32'(bit_count), 32'd24);
    exp_a = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd6, 3'd3, 3'd6, 3'd0};
    for (int j = 0; j < 8; j++) pop_check($sformatf("full_w%0d", j), exp_a[j], j == 0, j == 7);
    check("full_drained_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("full_drained_count",  32'(bit_count),     32'd0);

    // 3. Short frame FF -> 7,7,6 with padding, bit_count 8,5,2,0.
    send(8'hFF, 1'b1, 1'b1);
    check("short_bc0", 32'(bit_count), 32'd8);
    pop_check("short_w0", 3'd7, 1'b1, 1'b0);
    check("short_bc1", 32'(bit_count), 32'd5);
    pop_check("short_w1", 3'd7, 1'b0, 1'b0);
    check("short_bc2", 32'(bit_count), 32'd2);
    pop_check("short_w2", 3'd6, 1'b0, 1'b1);
    check("short_bc3", 32'(bit_count), 32'd0);
    check("short_tvalid", 32'(m_axis_tvalid), 32'd0);

    // 4. Backpressure: 12 bytes fill all pages, the 13th waits for a freed page.
    for (int i = 0; i < 12; i++) send(8'(i + 1), i == 0, 1'b0);
    check("bp_bit_count_full", 32'(bit_count), 32'd96);
    @(negedge clk);
    s_axis_tdata  = 8'h0D;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    #1;
    check("bp_blocked", 32'(s_axis_tnext), 32'd0);
    exp_b = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd1, 3'd0, 3'd0, 3'd3};
    for (int j = 0; j < 7; j++) pop_check($sformatf("bp_p0_w%0d", j), exp_b[j], j == 0, 1'b0);
    check("bp_still_blocked", 32'(s_axis_tnext), 32'd0);
    pop_check("bp_p0_w7", exp_b[7], 1'b0, 1'b0);
    check("bp_unblocked_after_free", 32'(s_axis_tnext), 32'd1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("bp_bit_count_after", 32'(bit_count), 32'd80);
    exp_c = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd4, 3'd0, 3'd6};
    for (int j = 0; j < 8; j++) pop_check($sformatf("bp_p1_w%0d", j), exp_c[j], 1'b0, 1'b0);
    n      = 0;
    last_d = '0;
    last_l = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (!m_axis_tvalid) break;
      last_d       = m_axis_tdata;
      last_l       = m_axis_tlast;
      m_axis_tnext = 1'b1;
      @(posedge clk);
      #1;
      m_axis_tnext = 1'b0;
      n++;
    end
    check("bp_drain_words", 32'(n), 32'd19);
    check("bp_drain_last_data", 32'(last_d), 32'd2);
    check("bp_drain_last_flag", 32'(last_l), 32'd1);
    check("bp_drain_bit_count", 32'(bit_count), 32'd0);

    // 5. Frame error: 11(tfirst), 22(tfirst), 33(tlast).
    send(8'h11, 1'b1, 1'b0);
    check("ferr_idle", 32'(frame_err), 32'd0);
    send(8'h22, 1'b1, 1'b0);
    check("ferr_pulse", 32'(frame_err), 32'd1);
    send(8'h33, 1'b0, 1'b1);
    check("ferr_one_cycle", 32'(frame_err), 32'd0);
    pop_check("ferr_p0_w0", 3'd0, 1'b1, 1'b0);
    pop_check("ferr_p0_w1", 3'd4, 1'b0, 1'b0);
    pop_check("ferr_p0_w2", 3'd2, 1'b0, 1'b1);
    exp_a = '{3'd1, 3'd0, 3'd4, 3'd3, 3'd1, 3'd4, 3'd0, 3'd0};
    for (int j = 0; j < 6; j++) pop_check($sformatf("ferr_p1_w%0d", j), exp_a[j], j == 0, j == 5);
    check("ferr_drained", 32'(m_axis_tvalid), 32'd0);
    check("ferr_bit_count", 32'(bit_count), 32'd0);

    // 6. Async reset in the middle of emitting AA,BB,CC (5,2,5,3 popped first).
    send(8'hAA, 1'b1, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b1);
    pop_check("ar_w0", 3'd5, 1'b1, 1'b0);
    pop_check("ar_w1", 3'd2, 1'b0, 1'b0);
    pop_check("ar_w2", 3'd5, 1'b0, 1'b0);
    pop_check("ar_w3", 3'd3, 1'b0, 1'b0);
    check("ar_bit_count_before", 32'(bit_count), 32'd12);
    check("ar_tvalid_before", 32'(m_axis_tvalid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_tvalid_async", 32'(m_axis_tvalid), 32'd0);
    check("ar_tdata_async",  32'(m_axis_tdata),  32'd0);
    check("ar_bc_async",     32'(bit_count),     32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("ar_tvalid_after", 32'(m_axis_tvalid), 32'd0);
    check("ar_bc_after",     32'(bit_count),     32'd0);
    send(8'h80, 1'b1, 1'b1);
    pop_check("ar_fresh_w0", 3'd4, 1'b1, 1'b0);
    pop_check("ar_fresh_w1", 3'd0, 1'b0, 1'b0);
    pop_check("ar_fresh_w2", 3'd0, 1'b0, 1'b1);
    check("ar_fresh_bc", 32'(bit_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
